// File: rtl/pic_host_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pic_host_ctrl
// Brief    : CPU-side PIC master: intack handshake, vector read, EOI write.
//            `PIC_HOST_AUTO_EOI_EN: EOI issued right after the vector handshake.
// Revision : 1.0  initial release
// ============================================================================
module pic_host_ctrl #(
    parameter int unsigned ACK_CYCLES = 2,
    parameter int unsigned RD_CYCLES  = 2,
    parameter logic [7:0]  EOI_CMD    = 8'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pic_int,
    output logic       pic_intack,
    output logic [1:0] pic_select,
    output logic       pic_readwrite,
    inout  wire  [7:0] pic_data,
    output logic [7:0] vec_data,
    output logic       vec_valid,
    input  logic       vec_ready,
    input  logic       eoi_req,
    output logic       busy,
    output logic       spurious
);

    localparam logic [1:0]  c_SEL_OCR  = 2'b00;
    localparam logic        c_RW_READ  = 1'b1;
    localparam logic        c_RW_WRITE = 1'b0;
    localparam int unsigned c_CNT_MAX  = (ACK_CYCLES > RD_CYCLES) ? ACK_CYCLES : RD_CYCLES;
    localparam int unsigned c_CNT_W    = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_ACK_LAST = c_CNT_W'(ACK_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_RD_LAST  = c_CNT_W'(RD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ACK      = 3'd1,
        S_RDVEC    = 3'd2,
        S_DELIVER  = 3'd3,
        S_WAIT_EOI = 3'd4,
        S_EOI_WR   = 3'd5,
        S_GAP      = 3'd6
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_drive;

    assign pic_select = c_SEL_OCR;
    assign pic_data   = r_drive ? EOI_CMD : 8'hzz;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_drive       <= 1'b0;
            pic_intack    <= 1'b0;
            pic_readwrite <= c_RW_READ;
            vec_data      <= 8'h00;
            vec_valid     <= 1'b0;
            busy          <= 1'b0;
            spurious      <= 1'b0;
        end else begin
            spurious <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (pic_int) begin
                        r_state    <= S_ACK;
                        r_cnt      <= '0;
                        pic_intack <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                S_ACK: begin
                    // A request withdrawn during acknowledge aborts the whole transaction
                    if (!pic_int) begin
                        r_state    <= S_IDLE;
                        pic_intack <= 1'b0;
                        busy       <= 1'b0;
                        spurious   <= 1'b1;
                    end else if (r_cnt == c_ACK_LAST) begin
                        r_state    <= S_RDVEC;
                        r_cnt      <= '0;
                        pic_intack <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RDVEC: begin
                    if (r_cnt == c_RD_LAST) begin
                        vec_data  <= pic_data;
                        vec_valid <= 1'b1;
                        r_state   <= S_DELIVER;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DELIVER: begin
                    if (vec_ready) begin
                        vec_valid <= 1'b0;
`ifdef PIC_HOST_AUTO_EOI_EN
                        r_state       <= S_EOI_WR;
                        pic_readwrite <= c_RW_WRITE;
                        r_drive       <= 1'b1;
`else
                        r_state       <= S_WAIT_EOI;
`endif
                    end
                end
                S_WAIT_EOI: begin
                    if (eoi_req) begin
                        r_state       <= S_EOI_WR;
                        pic_readwrite <= c_RW_WRITE;
                        r_drive       <= 1'b1;
                    end
                end
                S_EOI_WR: begin
                    r_state       <= S_GAP;
                    pic_readwrite <= c_RW_READ;
                    r_drive       <= 1'b0;
                end
                S_GAP: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_cnt         <= '0;
                    r_drive       <= 1'b0;
                    pic_intack    <= 1'b0;
                    pic_readwrite <= c_RW_READ;
                    vec_valid     <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pic_host_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pic_host_ctrl
// Brief    : Directed bench for pic_host_ctrl with a cycle-timeline reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pic_host_ctrl;

    localparam int         ACK      = 2;
    localparam int         RD       = 2;
    localparam logic [7:0] EOI      = 8'h20;
    localparam logic [1:0] SEL_OCR  = 2'b00;
    localparam logic       RW_READ  = 1'b1;
    localparam logic       RW_WRITE = 1'b0;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic       pic_int   = 1'b0;
    logic       vec_ready = 1'b0;
    logic       eoi_req   = 1'b0;
    logic       pic_intack;
    logic [1:0] pic_select;
    logic       pic_readwrite;
    wire  [7:0] pic_data;
    logic [7:0] vec_data;
    logic       vec_valid;
    logic       busy;
    logic       spurious;

    logic [7:0] pic_vec    = 8'h00;
    logic       pic_drv_en = 1'b0;
    assign pic_data = pic_drv_en ? pic_vec : 8'hzz;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pic_host_ctrl #(
        .ACK_CYCLES (ACK),
        .RD_CYCLES  (RD),
        .EOI_CMD    (EOI)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pic_int       (pic_int),
        .pic_intack    (pic_intack),
        .pic_select    (pic_select),
        .pic_readwrite (pic_readwrite),
        .pic_data      (pic_data),
        .vec_data      (vec_data),
        .vec_valid     (vec_valid),
        .vec_ready     (vec_ready),
        .eoi_req       (eoi_req),
        .busy          (busy),
        .spurious      (spurious)
    );

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Timeline model: m_t counts cycles since the IRQ was taken (1 = first
    // acknowledge cycle); m_e tracks the EOI write (0) and turnaround (1).
    int         m_t      = -1;
    bit         m_hs     = 1'b0;
    int         m_e      = -1;
    bit         m_spur   = 1'b0;
    logic [7:0] m_vec    = 8'h00;
    bit         m_rd_nxt = 1'b0;

    // Emulated PIC drives the vector for exactly the read window
    always @(posedge clk or negedge reset) begin
        if (!reset) pic_drv_en <= 1'b0;
        else        pic_drv_en <= m_rd_nxt;
    end

    initial begin
        bit e_intack, e_busy, e_valid, e_write, e_rd;
        forever begin
            @(negedge clk);
            if (!reset) begin
                m_t = -1; m_hs = 1'b0; m_e = -1; m_spur = 1'b0;
                m_vec = 8'h00; m_rd_nxt = 1'b0;
            end
            e_intack = (m_t >= 1) && (m_t <= ACK);
            e_busy   = (m_t >= 1);
            e_rd     = (m_t > ACK) && (m_t <= ACK + RD);
            e_valid  = (m_t > ACK + RD) && !m_hs;
            e_write  = (m_e == 0);
            chk1("m_intack",   pic_intack,    e_intack);
            chk1("m_busy",     busy,          e_busy);
            chk1("m_valid",    vec_valid,     e_valid);
            chk1("m_spurious", spurious,      m_spur);
            chk1("m_rw",       pic_readwrite, e_write ? RW_WRITE : RW_READ);
            chk8("m_select",   {6'd0, pic_select}, {6'd0, SEL_OCR});
            chk8("m_vec",      vec_data,      m_vec);
            if (e_write)   chk8("m_bus_eoi", pic_data, EOI);
            else if (e_rd) chk8("m_bus_vec", pic_data, pic_vec);
            else           chk1("m_bus_z", (pic_data === 8'hzz), 1'b1);
            if (reset) begin
                m_spur = 1'b0;
                if (m_t < 0) begin
                    if (pic_int) m_t = 1;
                end else if (m_t <= ACK) begin
                    if (!pic_int) begin m_t = -1; m_spur = 1'b1; end
                    else m_t++;
                end else if (m_t <= ACK + RD) begin
                    if (m_t == ACK + RD) m_vec = pic_vec;
                    m_t++;
                end else if (!m_hs) begin
                    if (vec_ready) begin
                        m_hs = 1'b1;
`ifdef PIC_HOST_AUTO_EOI_EN
                        m_e = 0;
`else
                        m_e = -1;
`endif
                    end
                end else if (m_e < 0) begin
                    if (eoi_req) m_e = 0;
                end else if (m_e == 0) begin
                    m_e = 1;
                end else begin
                    m_t = -1; m_hs = 1'b0; m_e = -1;
                end
                m_rd_nxt = (m_t > ACK) && (m_t <= ACK + RD);
            end
        end
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        // Reset held with a pending interrupt
        reset = 1'b0; pic_int = 1'b1;
        step(3);
        chk1("t1_intack", pic_intack, 1'b0);
        chk1("t1_busy",   busy,       1'b0);
        chk1("t1_valid",  vec_valid,  1'b0);
        chk8("t1_vec",    vec_data,   8'h00);
        chk1("t1_bus_z",  (pic_data === 8'hzz), 1'b1);
        reset = 1'b1; pic_int = 1'b0;
        step(3);

        // Basic transaction, vector 0x41
        pic_vec = 8'h41; vec_ready = 1'b1; pic_int = 1'b1;
        step(1); chk1("t2_ack_c1", pic_intack, 1'b1);
        step(1); chk1("t2_ack_c2", pic_intack, 1'b1);
        step(1); pic_int = 1'b0; chk1("t2_ack_c3", pic_intack, 1'b0);
        step(1); chk1("t2_valid_c4", vec_valid, 1'b0);
        step(1); chk1("t2_valid_c5", vec_valid, 1'b1); chk8("t2_vec_c5", vec_data, 8'h41);
        step(1); vec_ready = 1'b0;
`ifdef PIC_HOST_AUTO_EOI_EN
        chk1("t6_rw_write", pic_readwrite, RW_WRITE);
        chk8("t6_eoi_data", pic_data, 8'h20);
        step(1);
        chk1("t6_bus_z",   (pic_data === 8'hzz), 1'b1);
        chk1("t6_rw_read", pic_readwrite, RW_READ);
        step(1); chk1("t6_idle", busy, 1'b0);
`else
        chk1("t2_valid_c6", vec_valid, 1'b0);
        chk1("t2_no_write", pic_readwrite, RW_READ);
        eoi_req = 1'b1;
        step(1); eoi_req = 1'b0;
        chk1("t2_rw_write", pic_readwrite, RW_WRITE);
        chk8("t2_eoi_data", pic_data, 8'h20);
        step(1);
        chk1("t2_bus_z",   (pic_data === 8'hzz), 1'b1);
        chk1("t2_rw_read", pic_readwrite, RW_READ);
        chk1("t2_gap_busy", busy, 1'b1);
        step(1); chk1("t2_idle", busy, 1'b0);
`endif
        // Stray EOI request in IDLE must be ignored
        eoi_req = 1'b1;
        step(1); eoi_req = 1'b0;
        step(1); chk1("t2_stray_eoi", pic_readwrite, RW_READ);

        // Core stalls vec_ready for 10 cycles
        pic_vec = 8'h41; vec_ready = 1'b0; pic_int = 1'b1;
        step(3); pic_int = 1'b0;
        step(2);
        for (int i = 0; i < 10; i++) begin
            chk1("t3_hold_valid", vec_valid, 1'b1);
            chk8("t3_hold_vec",   vec_data,  8'h41);
            step(1);
        end
        vec_ready = 1'b1;
        chk1("t3_valid_pre", vec_valid, 1'b1);
        step(1); vec_ready = 1'b0;
        chk1("t3_valid_post", vec_valid, 1'b0);
`ifndef PIC_HOST_AUTO_EOI_EN
        eoi_req = 1'b1;
        step(1); eoi_req = 1'b0;
`endif
        step(3);

        // Request withdrawn during the second acknowledge cycle
        pic_int = 1'b1;
        step(1); chk1("t4_ack_c1", pic_intack, 1'b1);
        step(1); pic_int = 1'b0;
        step(1);
        chk1("t4_spurious", spurious,   1'b1);
        chk1("t4_intack",   pic_intack, 1'b0);
        chk1("t4_busy",     busy,       1'b0);
        step(1); chk1("t4_spur_once", spurious, 1'b0);
        step(8);
        chk1("t4_no_valid", vec_valid,     1'b0);
        chk1("t4_no_write", pic_readwrite, RW_READ);

        // Reset while waiting for EOI (in DELIVER for the auto-EOI build)
        pic_vec = 8'h5A; pic_int = 1'b1;
`ifdef PIC_HOST_AUTO_EOI_EN
        vec_ready = 1'b0;
`else
        vec_ready = 1'b1;
`endif
        step(3); pic_int = 1'b0;
        step(3); chk1("t5_busy_pre", busy, 1'b1); chk8("t5_vec_pre", vec_data, 8'h5A);
        step(1); reset = 1'b0; eoi_req = 1'b1;
        #1;
        chk1("t5_busy_rst",  busy,      1'b0);
        chk1("t5_valid_rst", vec_valid, 1'b0);
        chk8("t5_vec_rst",   vec_data,  8'h00);
        chk1("t5_rw_rst",    pic_readwrite, RW_READ);
        chk1("t5_bus_rst",   (pic_data === 8'hzz), 1'b1);
        step(1); reset = 1'b1; vec_ready = 1'b0;
        step(1); eoi_req = 1'b0;
        chk1("t5_no_eoi", pic_readwrite, RW_READ);
        step(2);

        // Fresh transaction after reset
        pic_vec = 8'h33; vec_ready = 1'b1; pic_int = 1'b1;
        step(3); pic_int = 1'b0;
        step(2); chk1("t5_fresh_valid", vec_valid, 1'b1); chk8("t5_fresh_vec", vec_data, 8'h33);
        step(1); vec_ready = 1'b0;
`ifndef PIC_HOST_AUTO_EOI_EN
        eoi_req = 1'b1;
        step(1); eoi_req = 1'b0;
        chk8("t5_fresh_eoi", pic_data, 8'h20);
`else
        chk8("t5_fresh_eoi", pic_data, 8'h20);
        step(1);
`endif
        step(4);
        chk1("t5_fresh_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
